reg_scoreboard: RTL and testbench

Parametrised register-busy scoreboard for the pipelined CPU. Its decode stage turns issue and writeback destination addresses into one-hot vectors, generalising the fixed 3-to-8 write-register decoder to any address width. It keeps a registered busy bit per architectural register and reports source hazards to the issue/stall logic. It sits beside the register file, between decode (issue) and writeback.

---
 rtl/reg_scoreboard.sv | 88 ++++++++
 tb/tb_reg_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: one busy bit per architectural register, set on
// issue and cleared on writeback, with combinational source-hazard reporting
// and a sticky flag for writebacks to registers that were not busy.
module reg_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_EN  = 1,
    parameter int unsigned ZERO_IDX = 31
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd,
    output logic                      issue_ready,
    input  logic                      wb_valid,
    input  logic [ADDR_W-1:0]         wb_rd,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         src_a,
    input  logic [ADDR_W-1:0]         src_b,
    output logic                      src_a_busy,
    output logic                      src_b_busy,
    output logic [(2**ADDR_W)-1:0]    busy_vec,
    output logic [ADDR_W:0]           pending_cnt,
    output logic                      wb_err
);

    localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wb_err_q, wb_err_d;
    logic [NUM_REGS-1:0] set_oh, clr_oh;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_EN != 0) && (a == ZERO_A);
    endfunction

    // Hazard and issue-ready evaluation; a same-cycle writeback is forwarded
    always_comb begin
        issue_ready = is_zero(issue_rd) || !busy_q[issue_rd] ||
                      (wb_valid && (wb_rd == issue_rd));
        src_a_busy  = busy_q[src_a] && !(wb_valid && (wb_rd == src_a)) &&
                      !is_zero(src_a);
        src_b_busy  = busy_q[src_b] && !(wb_valid && (wb_rd == src_b)) &&
                      !is_zero(src_b);
    end

    // Decode issue/writeback destinations into one-hot set/clear vectors
    always_comb begin
        set_oh = '0;
        clr_oh = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            set_oh[i] = issue_valid && issue_ready && (issue_rd == ADDR_W'(i)) &&
                        !is_zero(ADDR_W'(i));
            clr_oh[i] = wb_valid && (wb_rd == ADDR_W'(i));
        end
    end

    // Next busy state (flush > set > clear), its popcount, and sticky error
    always_comb begin
        busy_d = flush ? '0 : ((busy_q & ~clr_oh) | set_oh);
        cnt_d  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
        wb_err_d = wb_err_q ||
                   (wb_valid && !busy_q[wb_rd] && !flush && !is_zero(wb_rd));
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = cnt_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (ADDR_W=5, zero register 31):
// directed scenarios followed by randomized traffic against a bit-array model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, wb_valid, flush;
    logic [4:0]  issue_rd, wb_rd, src_a, src_b;
    logic        issue_ready, src_a_busy, src_b_busy, wb_err;
    logic [31:0] busy_vec;
    logic [5:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: one flag per register plus the sticky error flag
    bit mbusy [32];
    bit merr;

    always #5 clk = ~clk;

    reg_scoreboard #(.ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .src_a(src_a), .src_b(src_b),
        .src_a_busy(src_a_busy), .src_b_busy(src_b_busy),
        .busy_vec(busy_vec), .pending_cnt(pending_cnt), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += mbusy[i];
        return n;
    endfunction

    function automatic logic model_src_busy(input logic [4:0] s);
        return mbusy[s] && !(wb_valid && wb_rd == s);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        merr = 0;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = '0; wb_valid = 0; wb_rd = '0;
        flush = 0; src_a = '0; src_b = '0;
    endtask

    // One clock cycle with the currently driven inputs: check every output
    // against the model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        logic exp_ready;
        bit   old_busy_wb;
        exp_ready = (issue_rd == 5'd31) || !mbusy[issue_rd] ||
                    (wb_valid && wb_rd == issue_rd);
        @(negedge clk);
        check("issue_ready", issue_ready, exp_ready);
        check("src_a_busy", src_a_busy, model_src_busy(src_a));
        check("src_b_busy", src_b_busy, model_src_busy(src_b));
        check("busy_vec", busy_vec, model_vec());
        check("pending_cnt", pending_cnt, model_cnt());
        check("wb_err", wb_err, merr);
        old_busy_wb = mbusy[wb_rd];
        if (flush) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
        end else begin
            if (wb_valid && !old_busy_wb && wb_rd != 5'd31) merr = 1;
            if (wb_valid) mbusy[wb_rd] = 0;
            if (issue_valid && exp_ready && issue_rd != 5'd31) mbusy[issue_rd] = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst_n = 0;
        repeat (n) @(posedge clk);
        #1;
        model_clear();
        check("rst_busy_vec", busy_vec, 32'h0);
        check("rst_pending", pending_cnt, 6'd0);
        check("rst_wb_err", wb_err, 1'b0);
        check("rst_ready", issue_ready, 1'b1);
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst_n = 0;
        #2;
        do_reset(3);
        cycle();

        // Claim r7 and observe the hazard one cycle later
        issue_valid = 1; issue_rd = 5'd7;
        cycle();
        issue_valid = 1; issue_rd = 5'd7; src_a = 5'd7; #1;
        check("hazard_a", src_a_busy, 1'b1);
        check("claim_vec", busy_vec, 32'h0000_0080);
        check("claim_cnt", pending_cnt, 6'd1);
        check("reissue_ready", issue_ready, 1'b0);
        cycle();
        check("reissue_vec", busy_vec, 32'h0000_0080);

        // Writeback and reissue of r7 in the same cycle
        wb_valid = 1; wb_rd = 5'd7; #1;
        check("fwd_src_a", src_a_busy, 1'b0);
        check("fwd_ready", issue_ready, 1'b1);
        cycle();
        check("reuse_vec", busy_vec, 32'h0000_0080);
        check("reuse_cnt", pending_cnt, 6'd1);
        idle_inputs(); wb_valid = 1; wb_rd = 5'd7;
        cycle();
        idle_inputs();

        // Fill every register, the zero register is accepted but not marked
        for (int r = 0; r < 32; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            cycle();
        end
        idle_inputs();
        check("fill_vec", busy_vec, 32'h7FFF_FFFF);
        check("fill_cnt", pending_cnt, 6'd31);
        for (int r = 0; r < 31; r++) begin
            wb_valid = 1; wb_rd = 5'(r);
            cycle();
        end
        idle_inputs();
        check("drain_cnt", pending_cnt, 6'd0);

        // Flush overrides same-cycle issue and writeback
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            cycle();
        end
        flush = 1; issue_valid = 1; issue_rd = 5'd3; wb_valid = 1; wb_rd = 5'd5;
        cycle();
        idle_inputs();
        check("flush_vec", busy_vec, 32'h0);
        check("flush_cnt", pending_cnt, 6'd0);
        check("flush_err", wb_err, 1'b0);

        // Writeback to an idle register sets the sticky error
        wb_valid = 1; wb_rd = 5'd9;
        cycle();
        idle_inputs();
        check("err_set", wb_err, 1'b1);
        flush = 1;
        cycle();
        idle_inputs();
        check("err_sticky", wb_err, 1'b1);
        issue_valid = 1; issue_rd = 5'd4;
        cycle();
        idle_inputs();

        // Asynchronous reset mid-cycle clears state before the next edge
        #3 rst_n = 0;
        #1;
        check("async_err", wb_err, 1'b0);
        check("async_vec", busy_vec, 32'h0);
        check("async_ready", issue_ready, 1'b1);
        do_reset(2);

        // Randomized traffic with periodic resets
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset(2);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom);
            wb_valid    = ($urandom_range(0, 1) == 1);
            wb_rd       = 5'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                int start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (mbusy[(start + k) % 32]) begin
                        wb_rd = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            flush = ($urandom_range(0, 31) == 0);
            src_a = ($urandom_range(0, 1) == 1) ? wb_rd : 5'($urandom);
            src_b = ($urandom_range(0, 1) == 1) ? issue_rd : 5'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
